// File: rtl/channel_model_pkg.sv
// Shared defaults and constants for the channel model: parameter defaults,
// identity coefficient helper and the noise LFSR seed.
package channel_model_pkg;

    localparam int DEF_SIGNAL_RESOLUTION = 8;
    localparam int DEF_NUM_TAPS          = 4;
    localparam int DEF_COEF_WIDTH        = 8;
    localparam int DEF_COEF_FRAC         = 6;
    localparam int DEF_NOISE_BITS        = 3;

    localparam int                    LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] NOISE_SEED = 16'h0001;

    // Unity gain in a coefficient with the given number of fractional bits.
    function automatic int identity_coef(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/channel_noise_lfsr.sv
// Maximal-length 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances
// only when step_i is high; its low bits form a signed noise sample.
module channel_noise_lfsr
    import channel_model_pkg::*;
#(
    parameter int NOISE_BITS = DEF_NOISE_BITS
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         step_i,
    output logic signed [NOISE_BITS-1:0] noise_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic                  feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[LFSR_WIDTH-2:0], feedback};
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            lfsr_q <= NOISE_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise_o = lfsr_q[NOISE_BITS-1:0];

endmodule

// File: rtl/channel_model.sv
// FIR channel with programmable taps, rounding, optional LFSR noise and output
// saturation; stage 1 registers tap products, stage 2 the finished sample.
module channel_model
    import channel_model_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = DEF_SIGNAL_RESOLUTION,
    parameter int NUM_TAPS          = DEF_NUM_TAPS,
    parameter int COEF_WIDTH        = DEF_COEF_WIDTH,
    parameter int COEF_FRAC         = DEF_COEF_FRAC,
    parameter int NOISE_BITS        = DEF_NOISE_BITS,
    localparam int ADDR_W           = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic                                coef_wr_en,
    input  logic        [ADDR_W-1:0]            coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]        coef_wr_data,
    input  logic                                noise_en,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid
);

    localparam int TAP_BITS = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 0;
    localparam int PROD_W   = SIGNAL_RESOLUTION + COEF_WIDTH;
    localparam int ACC_W    = PROD_W + TAP_BITS;
    localparam int SUM_W    = ACC_W + 1;

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE   = COEF_WIDTH'(identity_coef(COEF_FRAC));
    localparam logic signed [SUM_W-1:0]      ROUND_HALF = SUM_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [SUM_W-1:0]      SAT_MAX    = SUM_W'((2 ** (SIGNAL_RESOLUTION - 1)) - 1);
    localparam logic signed [SUM_W-1:0]      SAT_MIN    = -SAT_MAX - SUM_W'(1);

    logic signed [SIGNAL_RESOLUTION-1:0] x_q    [NUM_TAPS];
    logic signed [SIGNAL_RESOLUTION-1:0] x_d    [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]        coef_q [NUM_TAPS];
    logic signed [PROD_W-1:0]            prod_q [NUM_TAPS];
    logic signed [PROD_W-1:0]            prod_d [NUM_TAPS];
    logic signed [NOISE_BITS-1:0]        noise_q, noise_w;
    logic signed [SIGNAL_RESOLUTION-1:0] out_q, out_d;
    logic                                stage1_valid_q, out_valid_q;
    logic signed [ACC_W-1:0]             acc;
    logic signed [SUM_W-1:0]             rounded, noisy;

    channel_noise_lfsr #(
        .NOISE_BITS (NOISE_BITS)
    ) u_noise (
        .clk     (clk),
        .rst_i   (rstn),
        .step_i  (signal_in_valid),
        .noise_o (noise_w)
    );

    // Products use the post-shift line so the new sample meets coef[0] at once.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            x_d[k] = (k == 0) ? signal_in : x_q[(k == 0) ? 0 : k - 1];
            prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(x_d[k]);
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        rounded = (SUM_W'(acc) + ROUND_HALF) >>> COEF_FRAC;
        noisy   = rounded + SUM_W'(noise_q);
        if (noisy > SAT_MAX) begin
            out_d = SAT_MAX[SIGNAL_RESOLUTION-1:0];
        end else if (noisy < SAT_MIN) begin
            out_d = SAT_MIN[SIGNAL_RESOLUTION-1:0];
        end else begin
            out_d = noisy[SIGNAL_RESOLUTION-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k]    <= '0;
                prod_q[k] <= '0;
                coef_q[k] <= (k == 0) ? COEF_ONE : '0;
            end
            noise_q        <= '0;
            stage1_valid_q <= 1'b0;
            out_q          <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            if (signal_in_valid) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    x_q[k]    <= x_d[k];
                    prod_q[k] <= prod_d[k];
                end
                noise_q <= noise_en ? noise_w : '0;
            end
            // A write in the same cycle as a sample lands after that sample's products.
            if (coef_wr_en && (int'(coef_wr_addr) < NUM_TAPS)) begin
                coef_q[coef_wr_addr] <= coef_wr_data;
            end
            stage1_valid_q <= signal_in_valid;
            if (stage1_valid_q) begin
                out_q <= out_d;
            end
            out_valid_q <= stage1_valid_q;
        end
    end

    assign signal_out       = out_q;
    assign signal_out_valid = out_valid_q;

endmodule

// File: tb/tb_channel_model.sv
// Self-checking bench for channel_model at default parameters, using a
// sample-level reference model (integer FIR, round, clamp, 2-sample delay).
module tb_channel_model;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] signal_in;
    logic              signal_in_valid;
    logic              coef_wr_en;
    logic        [1:0] coef_wr_addr;
    logic signed [7:0] coef_wr_data;
    logic              noise_en;
    logic signed [7:0] signal_out;
    logic              signal_out_valid;

    int checks   = 0;
    int failures = 0;

    int   m_coef [4];
    int   hist   [4];
    logic p_valid, exp_valid;
    int   p_val, exp_out;
    int   got [$];
    int   noise_run [2][$];

    always #5 clk = ~clk;

    channel_model dut (
        .clk              (clk),
        .rstn             (rst),
        .signal_in        (signal_in),
        .signal_in_valid  (signal_in_valid),
        .coef_wr_en       (coef_wr_en),
        .coef_wr_addr     (coef_wr_addr),
        .coef_wr_data     (coef_wr_data),
        .noise_en         (noise_en),
        .signal_out       (signal_out),
        .signal_out_valid (signal_out_valid)
    );

    // Drive one cycle, advance the reference model, sample 1 time unit after the edge.
    task automatic step(input logic rst_v, input logic vld, input int din,
                        input logic we, input int waddr, input int wdata);
        int y;
        rst             = rst_v;
        signal_in_valid = vld;
        signal_in       = 8'(din);
        coef_wr_en      = we;
        coef_wr_addr    = 2'(waddr);
        coef_wr_data    = 8'(wdata);
        if (rst_v) begin
            for (int k = 0; k < 4; k++) begin
                hist[k]   = 0;
                m_coef[k] = (k == 0) ? 64 : 0;
            end
            p_valid = 0; p_val = 0; exp_valid = 0; exp_out = 0;
        end else begin
            exp_valid = p_valid;
            if (p_valid) exp_out = p_val;
            if (vld) begin
                for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = din;
                y = 0;
                for (int k = 0; k < 4; k++) y += m_coef[k] * hist[k];
                y = (y + 32) >>> 6;
                if (y > 127) y = 127;
                if (y < -128) y = -128;
                p_val = y;
            end
            p_valid = vld;
            if (we && waddr < 4) m_coef[waddr] = wdata;
        end
        @(posedge clk);
        #1;
        if (signal_out_valid) got.push_back(int'(signal_out));
    endtask

    function automatic int rnd8();
        logic signed [7:0] b;
        b = 8'($urandom_range(0, 255));
        return int'(b);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, rnd8(), 1, 0, rnd8());
            checks++;
            if (signal_out_valid !== 1'b0 || signal_out !== 8'sd0) begin
                failures++;
                $display("FAIL reset_state valid=%0b out=%0d required valid=0 out=0",
                         signal_out_valid, signal_out);
            end
        end
    endtask

    task automatic test_identity();
        int din_t [7] = '{84, -28, 28, 0, 0, 0, 0};
        int vld_t [7] = '{1, 1, 1, 0, 0, 0, 0};
        int lit   [3] = '{84, -28, 28};
        got.delete();
        for (int i = 0; i < 7; i++) begin
            step(0, vld_t[i][0], din_t[i], 0, 0, 0);
            checks++;
            if (signal_out_valid !== exp_valid || signal_out !== 8'(exp_out)) begin
                failures++;
                $display("FAIL identity_cycle%0d valid=%0b out=%0d required valid=%0b out=%0d",
                         i, signal_out_valid, signal_out, exp_valid, exp_out);
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != lit[0] || got[1] != lit[1] || got[2] != lit[2]) begin
            failures++;
            $display("FAIL identity_sequence got=%p required=%p", got, lit);
        end
    endtask

    task automatic test_isi();
        int lit [4] = '{84, 42, 0, 0};
        step(0, 0, 0, 1, 0, 64);
        step(0, 0, 0, 1, 1, 32);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            step(0, (i < 4), (i == 0) ? 84 : 0, 0, 0, 0);
            checks++;
            if (signal_out_valid !== exp_valid || signal_out !== 8'(exp_out)) begin
                failures++;
                $display("FAIL isi_cycle%0d valid=%0b out=%0d required valid=%0b out=%0d",
                         i, signal_out_valid, signal_out, exp_valid, exp_out);
            end
        end
        checks++;
        if (got.size() != 4 || got[0] != lit[0] || got[1] != lit[1] || got[2] != lit[2] || got[3] != lit[3]) begin
            failures++;
            $display("FAIL isi_sequence got=%p required=%p", got, lit);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 1, 0, 127);
        step(0, 0, 0, 1, 1, 0);
        got.delete();
        step(0, 1, 84, 0, 0, 0);
        step(0, 1, -84, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (got.size() != 2 || got[0] != 127 || got[1] != -128) begin
            failures++;
            $display("FAIL saturation got=%p required='{127, -128}", got);
        end
        checks++;
        if (signal_out !== 8'(exp_out)) begin
            failures++;
            $display("FAIL saturation_hold out=%0d required=%0d", signal_out, exp_out);
        end
    endtask

    task automatic test_valid_gaps();
        int vld_t [7] = '{1, 0, 0, 1, 0, 0, 0};
        step(0, 0, 0, 1, 0, 64);
        step(0, 0, 0, 1, 1, 32);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        got.delete();
        for (int i = 0; i < 7; i++) begin
            step(0, vld_t[i][0], (i == 0) ? 84 : 0, 0, 0, 0);
            checks++;
            if (signal_out_valid !== exp_valid || signal_out !== 8'(exp_out)) begin
                failures++;
                $display("FAIL gaps_cycle%0d valid=%0b out=%0d required valid=%0b out=%0d",
                         i, signal_out_valid, signal_out, exp_valid, exp_out);
            end
        end
        checks++;
        if (got.size() != 2 || got[0] != 84 || got[1] != 42) begin
            failures++;
            $display("FAIL gaps_sequence got=%p required='{84, 42}", got);
        end
    endtask

    task automatic test_collision();
        step(1, 0, 0, 0, 0, 0);
        got.delete();
        step(0, 1, 84, 1, 0, 32);
        step(0, 1, 84, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (got.size() != 2 || got[0] != 84 || got[1] != 42) begin
            failures++;
            $display("FAIL collision got=%p required='{84, 42}", got);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(0, ($urandom_range(0, 9) < 7), rnd8(), ($urandom_range(0, 9) < 2),
                 int'($urandom_range(0, 3)), rnd8());
            checks++;
            if (signal_out_valid !== exp_valid || signal_out !== 8'(exp_out)) begin
                failures++;
                $display("FAIL random_cycle%0d valid=%0b out=%0d required valid=%0b out=%0d",
                         i, signal_out_valid, signal_out, exp_valid, exp_out);
            end
        end
    endtask

    task automatic test_reset_noise();
        int distinct;
        step(0, 1, 50, 0, 0, 0);
        step(1, 1, -50, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (signal_out_valid !== 1'b0 || signal_out !== 8'sd0) begin
                failures++;
                $display("FAIL midreset_flush%0d valid=%0b out=%0d required valid=0 out=0",
                         i, signal_out_valid, signal_out);
            end
        end
        got.delete();
        step(0, 1, 84, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (got.size() != 2 || got[0] != 84 || got[1] != 0) begin
            failures++;
            $display("FAIL midreset_identity got=%p required='{84, 0}", got);
        end
        noise_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step(1, 0, 0, 0, 0, 0);
            got.delete();
            for (int n = 0; n < 40; n++) begin
                if (r == 1) begin
                    repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0, 0);
                end
                step(0, 1, 0, 0, 0, 0);
            end
            step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            noise_run[r] = got;
            checks++;
            if (got.size() != 40) begin
                failures++;
                $display("FAIL noise_count run%0d got=%0d required=40", r, got.size());
            end
            foreach (got[i]) begin
                checks++;
                if (got[i] < -4 || got[i] > 3) begin
                    failures++;
                    $display("FAIL noise_range run%0d idx%0d out=%0d required within [-4,3]",
                             r, i, got[i]);
                end
            end
        end
        checks++;
        if (noise_run[0] != noise_run[1]) begin
            failures++;
            $display("FAIL noise_repeat run0=%p run1=%p", noise_run[0], noise_run[1]);
        end
        distinct = 0;
        foreach (noise_run[0][i]) if (noise_run[0][i] != noise_run[0][0]) distinct = 1;
        checks++;
        if (distinct == 0) begin
            failures++;
            $display("FAIL noise_active all samples=%0d required varying noise", noise_run[0][0]);
        end
        noise_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; signal_in_valid = 1'b0; signal_in = '0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; noise_en = 1'b0;
        #1;
        test_reset();
        test_identity();
        test_isi();
        test_saturation();
        test_valid_gaps();
        test_collision();
        test_random();
        test_reset_noise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_model.md
CHANNEL_MODEL -- requirements
Module: channel_model

Interface
REQ-001 SHALL have parameter SIGNAL_RESOLUTION, default 8: sample width, two's complement signed.
REQ-002 SHALL have parameter NUM_TAPS, default 4: FIR channel taps, legal range 1..16.
REQ-003 SHALL have parameter COEF_WIDTH, default 8: coefficient width, signed.
REQ-004 SHALL have parameter COEF_FRAC, default 6: coefficient fractional bits, so 1.0 = 2^COEF_FRAC.
REQ-005 SHALL have parameter NOISE_BITS, default 3: additive noise width, signed.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1: synchronous, active-high reset (asserted = 1 despite the name).
REQ-008 SHALL have port signal_in, input, SIGNAL_RESOLUTION: voltage-level sample from pam_4_encode.
REQ-009 SHALL have port signal_in_valid, input, 1: signal_in qualifier.
REQ-010 SHALL have port coef_wr_en, input, 1: coefficient write strobe.
REQ-011 SHALL have port coef_wr_addr, input, clog2(NUM_TAPS) (min 1): tap index.
REQ-012 SHALL have port coef_wr_data, input, COEF_WIDTH: new coefficient.
REQ-013 SHALL have port noise_en, input, 1: enables additive noise.
REQ-014 SHALL have port signal_out, output, SIGNAL_RESOLUTION: channel output sample.
REQ-015 SHALL have port signal_out_valid, output, 1: signal_out qualifier.

Function
REQ-016 SHALL keep a NUM_TAPS-deep delay line x[0..NUM_TAPS-1]; shifts only on cycles with signal_in_valid=1, x[0] <= signal_in.
REQ-017 SHALL compute y = sum(coef[k]*x[k]) over the post-shift delay line, full-precision accumulator of SIGNAL_RESOLUTION+COEF_WIDTH+clog2(NUM_TAPS) bits, no intermediate overflow.
REQ-018 SHALL round by adding 2^(COEF_FRAC-1), then arithmetic right shift by COEF_FRAC.
REQ-019 SHALL, with noise_en=1, add the current noise sample (range -2^(NOISE_BITS-1)..2^(NOISE_BITS-1)-1) after rounding; noise_en=0 adds zero.
REQ-020 SHALL saturate the final result to [-2^(SIGNAL_RESOLUTION-1), 2^(SIGNAL_RESOLUTION-1)-1].
REQ-021 SHALL have fixed latency of 2 cycles: stage 1 registers tap products, stage 2 registers sum/round/noise/saturate; signal_out_valid is signal_in_valid delayed 2 cycles.
REQ-022 SHALL hold signal_out at its last value while signal_out_valid=0.
REQ-023 SHALL write coef[coef_wr_addr] <= coef_wr_data when coef_wr_en=1; addr >= NUM_TAPS ignored.
REQ-024 SHALL, on simultaneous coef write and signal_in_valid, compute that sample with the old coefficients; the new value applies from the next accepted sample.
REQ-025 SHALL advance the noise generator once per accepted sample only, so output is reproducible independent of valid gaps.

Reset
REQ-026 SHALL, while rstn=1, clear delay line, product and output registers to 0, signal_out_valid to 0, in-flight samples discarded.
REQ-027 SHALL reset coefficients to identity: coef[0]=2^COEF_FRAC, others 0 (requires COEF_WIDTH > COEF_FRAC+1).
REQ-028 SHALL reseed the noise generator to a fixed non-zero seed 1.
REQ-029 SHALL accept input on the first cycle after rstn deasserts.

Structure
REQ-030 SHALL place default parameter values, identity-coefficient constant and noise seed in shared package channel_model_pkg.
REQ-031 SHALL instantiate one sub-module channel_noise_lfsr (maximal-length LFSR, step-enable input, NOISE_BITS signed output).
REQ-032 SHALL use no vendor primitives; multipliers inferred.

Verification (defaults, noise_en=0 unless stated)
REQ-033 Identity after reset: inputs 84, -28, 28 on consecutive valid cycles -> signal_out 84, -28, 28 with valid 2 cycles later.
REQ-034 ISI: write coef[0]=64, coef[1]=32; impulse 84 then zeros -> outputs 84, 42, 0, 0.
REQ-035 Saturation: coef[0]=127; input 84 -> 127; input -84 -> -128.
REQ-036 Valid gaps: 84, bubble, bubble, 0 with coef{64,32} -> outputs 84, 42; exactly two valid pulses.
REQ-037 Write collision: coef[0] write 32 in same cycle as input 84 -> output 84; next input 84 -> 42.
REQ-038 Mid-stream reset plus noise: rstn pulse with two samples in flight -> no valid for those samples, coefs back to identity; noise_en=1 constant input 0 -> output within [-4,3], identical sequence across two runs.
